// File: rtl/decoder_nxm_seq.sv
// ============================================================================
//  Module   : decoder_nxm_seq
//  Purpose  : Registered SEL_W-to-NUM_OUT one-hot decoder with an auto-scan
//             mode that steps the active line through all outputs, dwelling
//             DWELL cycles on each (display multiplexing / strobe driving).
//  Ports    : clk   - clock, rising edge
//             rst_n - synchronous active-low reset
//             en    - enable; 0 drives all output lines inactive
//             mode  - 0 = direct decode of sel, 1 = auto scan
//             sel   - select index (direct mode only)
//             o     - one-hot output, registered
//             idx   - index currently driven, registered
//             err   - sel out of range (direct mode), registered
//             wrap  - one-cycle pulse when the scan returns to index 0
//  Options  : define DEC_ACTIVE_LOW_EN to drive o active-low (active line 0,
//             inactive lines 1). idx/err/wrap are unaffected.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_nxm_seq #(
  parameter int SEL_W   = 2,
  parameter int NUM_OUT = 4,
  parameter int DWELL   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] o,
  output logic [SEL_W-1:0]   idx,
  output logic               err,
  output logic               wrap
);

  // Dwell counter only has to reach DWELL-1; keep at least one bit so the
  // DWELL=1 build still has a legal (constant-zero) register.
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [SEL_W-1:0]   IDX_LAST  = SEL_W'(NUM_OUT - 1);
  localparam logic [SEL_W-1:0]   IDX_ONE   = SEL_W'(1);
  localparam logic [NUM_OUT-1:0] OH_FIRST  = NUM_OUT'(1);
  // One extra bit so NUM_OUT = 2^SEL_W is representable in the range check.
  localparam logic [SEL_W:0]     NUM_OUT_V = (SEL_W + 1)'(NUM_OUT);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t             r_state;
  logic [NUM_OUT-1:0] r_onehot;
  logic [SEL_W-1:0]   r_idx;
  logic               r_err;
  logic               r_wrap;
  logic [CNT_W-1:0]   r_cnt;

  state_t             w_state_nxt;
  logic [NUM_OUT-1:0] w_onehot_nxt;
  logic [SEL_W-1:0]   w_idx_nxt;
  logic               w_err_nxt;
  logic               w_wrap_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_sel_ok;

  assign w_sel_ok = ({1'b0, sel} < NUM_OUT_V);

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_OFF;
      r_onehot <= '0;
      r_idx    <= '0;
      r_err    <= 1'b0;
      r_wrap   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_onehot <= w_onehot_nxt;
      r_idx    <= w_idx_nxt;
      r_err    <= w_err_nxt;
      r_wrap   <= w_wrap_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / next-output logic. The state is chosen fresh each cycle from
  // en/mode; r_state only remembers where we were so that scan entry can be
  // distinguished from steady-state scanning.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = ST_OFF;
    w_onehot_nxt = '0;
    w_idx_nxt    = r_idx;
    w_err_nxt    = 1'b0;
    w_wrap_nxt   = 1'b0;
    w_cnt_nxt    = '0;

    if (en) begin
      w_state_nxt = mode ? ST_SCAN : ST_DIRECT;
    end

    unique case (w_state_nxt)
      ST_DIRECT: begin
        if (w_sel_ok) begin
          w_onehot_nxt = OH_FIRST << sel;
          w_idx_nxt    = sel;
        end else begin
          // Out-of-range select: blank the lines and keep the last index.
          w_err_nxt    = 1'b1;
        end
      end

      ST_SCAN: begin
        if (r_state != ST_SCAN) begin
          // Entry always restarts at line 0 without a wrap pulse.
          w_onehot_nxt = OH_FIRST;
          w_idx_nxt    = '0;
        end else if (r_cnt == CNT_MAX) begin
          if (r_idx == IDX_LAST) begin
            w_onehot_nxt = OH_FIRST;
            w_idx_nxt    = '0;
            w_wrap_nxt   = 1'b1;
          end else begin
            w_onehot_nxt = {r_onehot[NUM_OUT-2:0], 1'b0};
            w_idx_nxt    = r_idx + IDX_ONE;
          end
        end else begin
          w_onehot_nxt = r_onehot;
          w_cnt_nxt    = r_cnt + CNT_ONE;
        end
      end

      default: begin
        // ST_OFF: defaults above (lines off, idx held).
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output stage: only the polarity of o differs between builds.
  // --------------------------------------------------------------------------
`ifdef DEC_ACTIVE_LOW_EN
  assign o = ~r_onehot;
`else
  assign o = r_onehot;
`endif

  assign idx  = r_idx;
  assign err  = r_err;
  assign wrap = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_decoder_nxm_seq.sv
// ============================================================================
//  Module   : tb_decoder_nxm_seq
//  Purpose  : Self-checking bench for decoder_nxm_seq. Three instances share
//             one stimulus stream: A (SEL_W=2, NUM_OUT=4, DWELL=4),
//             B (NUM_OUT=3, DWELL=1, exercises out-of-range selects) and
//             C (NUM_OUT=4, DWELL=1). Each is compared every cycle against a
//             behavioural model that derives the scan position from the time
//             spent in scan mode.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decoder_nxm_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [1:0] sel;

  logic [3:0] a_o;
  logic [1:0] a_idx;
  logic       a_err;
  logic       a_wrap;
  logic [2:0] b_o;
  logic [1:0] b_idx;
  logic       b_err;
  logic       b_wrap;
  logic [3:0] c_o;
  logic [1:0] c_idx;
  logic       c_err;
  logic       c_wrap;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] o;
    logic [1:0] idx;
    logic       err;
    logic       wrap;
    bit         in_scan;
    int         t;
  } model_t;

  model_t m [3];
  localparam int NS [3] = '{4, 3, 4};
  localparam int DS [3] = '{4, 1, 1};

  decoder_nxm_seq #(.SEL_W(2), .NUM_OUT(4), .DWELL(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
    .o(a_o), .idx(a_idx), .err(a_err), .wrap(a_wrap)
  );

  decoder_nxm_seq #(.SEL_W(2), .NUM_OUT(3), .DWELL(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
    .o(b_o), .idx(b_idx), .err(b_err), .wrap(b_wrap)
  );

  decoder_nxm_seq #(.SEL_W(2), .NUM_OUT(4), .DWELL(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
    .o(c_o), .idx(c_idx), .err(c_err), .wrap(c_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour for one edge. In scan mode the active line is simply
  // (cycles since entry / DWELL) mod NUM_OUT, and wrap fires at every full
  // period after entry.
  function automatic model_t model_step(model_t cur, int n, int d,
                                        logic r, logic e, logic md, logic [1:0] s);
    model_t nx;
    int pos;
    nx      = cur;
    nx.wrap = 1'b0;
    nx.err  = 1'b0;
    if (!r) begin
      nx.o = '0; nx.idx = '0; nx.in_scan = 1'b0; nx.t = 0;
    end else if (!e) begin
      nx.o = '0; nx.in_scan = 1'b0;
    end else if (!md) begin
      nx.in_scan = 1'b0;
      if (int'(s) < n) begin
        nx.o   = 4'(1 << s);
        nx.idx = s;
      end else begin
        nx.o   = '0;
        nx.err = 1'b1;
      end
    end else begin
      if (!cur.in_scan) begin
        nx.in_scan = 1'b1;
        nx.t       = 0;
      end else begin
        nx.t = cur.t + 1;
      end
      pos     = (nx.t / d) % n;
      nx.idx  = 2'(pos);
      nx.o    = 4'(1 << pos);
      nx.wrap = (nx.t > 0) && (nx.t % (n * d) == 0);
    end
    return nx;
  endfunction

  function automatic logic [31:0] line_level(logic [3:0] v, int n);
    logic [31:0] mask;
    mask = (32'd1 << n) - 32'd1;
`ifdef DEC_ACTIVE_LOW_EN
    return (~{28'd0, v}) & mask;
`else
    return {28'd0, v} & mask;
`endif
  endfunction

  task automatic check_inst(input string nm, input int i, input logic [3:0] o,
                            input logic [1:0] ix, input logic er, input logic wr);
    check({nm, ".o"},    {28'd0, o},  line_level(m[i].o, NS[i]));
    check({nm, ".idx"},  {30'd0, ix}, {30'd0, m[i].idx});
    check({nm, ".err"},  {31'd0, er}, {31'd0, m[i].err});
    check({nm, ".wrap"}, {31'd0, wr}, {31'd0, m[i].wrap});
  endtask

  // One clock: advance the models on the edge, sample the DUTs 1 time unit later.
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      m[i] = model_step(m[i], NS[i], DS[i], rst_n, en, mode, sel);
    end
    #1;
    check_inst("A", 0, a_o, a_idx, a_err, a_wrap);
    check_inst("B", 1, {1'b0, b_o}, b_idx, b_err, b_wrap);
    check_inst("C", 2, c_o, c_idx, c_err, c_wrap);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m[i] = '{o: '0, idx: '0, err: 1'b0, wrap: 1'b0, in_scan: 1'b0, t: 0};
    end

    // Reset held with scan requested.
    rst_n = 1'b0; en = 1'b1; mode = 1'b1; sel = 2'd0;
    repeat (3) step();

    // Scan from release: wrap on A only after a full 16-cycle period.
    rst_n = 1'b1;
    repeat (20) step();

    // Direct decode of every select value (3 is out of range for B).
    mode = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      step();
    end
    en = 1'b0;
    repeat (2) step();

    // Leave scan mid-dwell (A at idx 2, counter 1), then re-enter.
    en = 1'b1; mode = 1'b1;
    repeat (10) step();
    mode = 1'b0; sel = 2'd1;
    step();
    mode = 1'b1;
    repeat (6) step();

    // Out-of-range then in-range on B.
    mode = 1'b0; sel = 2'd3;
    step();
    sel = 2'd1;
    step();

    // Randomised traffic including occasional mid-run resets.
    repeat (400) begin
      rst_n = ($urandom_range(0, 49) != 0);
      en    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      sel   = 2'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
